clk_en_nco: RTL and testbench
=============================

// Module: clk_en_nco
// PURPOSE
// - Multi-channel fractional clock-enable generator (NCO), one refclk domain.
// - Each channel emits 1-cycle enable pulses at f_ref*inc/2^ACC_W.
// - Replaces fixed PLL output taps for slow core clocks: per-channel runtime
//   retune, glitch-free frequency change at wrap, phase preset, lock reporting.
// PARAMETERS
// - CHANNELS     4            number of independent enable channels (1..16)
// - ACC_W        32           phase accumulator width, bits
// - DEFAULT_INC  32'h0        increment loaded into every channel at reset (0 = stopped)
// - LOCK_CYCLES  16           enable pulses after an update before ch_locked sets (>=1)
// - CH_W         derived      $clog2(CHANNELS), min 1
// PORTS
// - refclk       in   1         single clock, all logic rising-edge
// - rst_n        in   1         asynchronous active-low reset
// - cfg_valid    in   1         config request valid
// - cfg_ready    out  1         config buffer empty, request accepted on valid&ready
// - cfg_ch       in   CH_W      target channel; values >= CHANNELS accepted and discarded
// - cfg_inc      in   ACC_W     new increment
// - cfg_phase    in   ACC_W     accumulator preset applied with the new increment
// - en_out       out  CHANNELS  per-channel enable pulse
// - ch_locked    out  CHANNELS  per-channel settled flag
// - locked       out  1         AND of ch_locked
// - sync_req     in   1         (CLK_EN_NCO_SYNC_EN only) realign all channels
// BEHAVIOUR
// - Reset (async assert, sync release): acc=0, inc=DEFAULT_INC, phase_reg=0,
//   pending buffer empty, en_out=0, ch_locked=0, locked=0, cfg_ready=1.
// - Per channel, per cycle: sum={1'b0,acc}+{1'b0,inc}; acc<=sum[ACC_W-1:0];
//   en_out[i]<=sum[ACC_W] (registered, 1-cycle latency). Modulo-2^ACC_W wrap.
// - inc=0: channel stopped, en_out=0, ch_locked=0. inc=2^ACC_W-1: pulse on
//   every cycle except one per 2^ACC_W.
// - Config handshake: single-entry pending buffer {ch,inc,phase}.
//   cfg_ready = buffer empty (registered). Accept on cfg_valid&cfg_ready; cfg_ready
//   falls next cycle. cfg_valid while !cfg_ready ignored; requester holds.
// - Apply: on target channel's wrap cycle (sum[ACC_W]=1) acc<=phase,
//   inc<=new inc, phase_reg<=phase; the wrap pulse itself is still emitted.
//   If current inc=0, apply on the cycle after accept. Buffer clears on apply;
//   cfg_ready rises the cycle after apply. Invalid cfg_ch: cleared next cycle,
//   no channel changes.
// - Lock: on apply, channel lock counter<=0 and ch_locked<=0; counter increments
//   per en_out pulse, saturates at LOCK_CYCLES; ch_locked=1 when counter==LOCK_CYCLES.
//   Reset also clears counters; DEFAULT_INC!=0 channels lock after LOCK_CYCLES pulses.
// - locked registered from ch_locked (1 extra cycle).
// - Simultaneous apply on one channel and wrap on others: independent.
// - Reset mid-operation: pending request dropped, no partial apply.
// CONFIGURATION
// - CLK_EN_NCO_SYNC_EN defined: sync_req port present. Cycle with sync_req=1:
//   every channel acc<=phase_reg, lock counters<=0, ch_locked<=0, en_out<=0
//   for that cycle. Priority over a same-cycle apply; pending entry retained,
//   applied at next wrap after sync. sync_req level-held: channels frozen at phase_reg.
// - Undefined: no sync_req port; channels realign only via individual config.
// TESTING
// - Bench instance ACC_W=8, CHANNELS=4, LOCK_CYCLES=4, DEFAULT_INC=8'h40.
// - Reset release -> each en_out pulses every 4 cycles, all in phase; locked=1 after
//   4 pulses + 1 cycle.
// - cfg ch1 inc=8'h80 phase=0 -> ch1 applies at next wrap; then pulses every 2 cycles,
//   no runt pulse; ch1_locked low for exactly 4 pulses; other channels unaffected.
// - Back-to-back cfg_valid for ch2 -> 2nd held off (cfg_ready=0) until ch2 wrap apply;
//   both updates applied in order.
// - cfg ch3 inc=0 then inc=8'h20 -> ch3 stops, ch3_locked=0; 2nd applies next cycle,
//   pulses every 8 cycles.
// - cfg_ch=5 (invalid) and rst_n pulse mid-pending -> no channel change; reset returns
//   all outputs to reset values, cfg_ready=1.
// - SYNC_EN: phases 0,40,80,C0 then sync_req -> all channels restart from phase_reg;
//   staggered pulses every 4 cycles; locked drops then returns.

Source files
------------

// File: rtl/clk_en_nco_if.sv
// Configuration request channel for clk_en_nco.
// Requester drives {ch, inc, phase} under valid; the NCO returns ready.
interface clk_en_nco_if #(
   parameter int CH_W  = 2,
   parameter int ACC_W = 32
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [ACC_W-1:0] cfg_inc;
   logic [ACC_W-1:0] cfg_phase;

   modport master (
      output cfg_valid,
      output cfg_ch,
      output cfg_inc,
      output cfg_phase,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_ch,
      input  cfg_inc,
      input  cfg_phase,
      output cfg_ready
   );
endinterface

// File: rtl/clk_en_nco.sv
// Multi-channel fractional clock-enable NCO with retune-at-wrap and lock flags.
// Optional CLK_EN_NCO_SYNC_EN adds sync_req to realign all channels to phase_reg.
module clk_en_nco #(
   parameter int               CHANNELS    = 4,
   parameter int               ACC_W       = 32,
   parameter logic [ACC_W-1:0] DEFAULT_INC = '0,
   parameter int               LOCK_CYCLES = 16,
   parameter int               CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                refclk,
   input  logic                rst_n,
   clk_en_nco_if.slave         cfg,
`ifdef CLK_EN_NCO_SYNC_EN
   input  logic                sync_req,
`endif
   output logic [CHANNELS-1:0] en_out,
   output logic [CHANNELS-1:0] ch_locked,
   output logic                locked
);

   localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
   localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);

   logic [CHANNELS-1:0][ACC_W-1:0] acc_q, acc_d;
   logic [CHANNELS-1:0][ACC_W-1:0] inc_q, inc_d;
   logic [CHANNELS-1:0][ACC_W-1:0] phr_q, phr_d;
   logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [CHANNELS-1:0]            en_q, en_d;
   logic                           locked_q, locked_d;

   logic                           pend_vld_q, pend_vld_d;
   logic [CH_W-1:0]                pend_ch_q, pend_ch_d;
   logic [ACC_W-1:0]               pend_inc_q, pend_inc_d;
   logic [ACC_W-1:0]               pend_phase_q, pend_phase_d;

   logic [CHANNELS-1:0][ACC_W:0]   sum;
   logic [CHANNELS-1:0]            wrap;
   logic [CHANNELS-1:0]            apply;
   logic                           accept;
   logic                           pend_bad;
   logic                           sync;

`ifdef CLK_EN_NCO_SYNC_EN
   assign sync = sync_req;
`else
   assign sync = 1'b0;
`endif

   assign accept   = cfg.cfg_valid & ~pend_vld_q;
   assign pend_bad = pend_vld_q &
                     ({{(32-CH_W){1'b0}}, pend_ch_q} >= 32'(CHANNELS));

   // A retune lands on the wrap cycle so the output never sees a runt period;
   // a stopped channel has no wrap to wait for and takes it immediately.
   always_comb begin
      sum   = '0;
      wrap  = '0;
      apply = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         sum[i]   = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
         wrap[i]  = sum[i][ACC_W];
         apply[i] = pend_vld_q & ~sync & (pend_ch_q == CH_W'(i)) &
                    (wrap[i] | (inc_q[i] == '0));
      end
   end

   always_comb begin
      acc_d = acc_q;
      inc_d = inc_q;
      phr_d = phr_q;
      cnt_d = cnt_q;
      en_d  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (sync) begin
            acc_d[i] = phr_q[i];
            cnt_d[i] = '0;
            en_d[i]  = 1'b0;
         end else if (apply[i]) begin
            acc_d[i] = pend_phase_q;
            inc_d[i] = pend_inc_q;
            phr_d[i] = pend_phase_q;
            cnt_d[i] = '0;
            en_d[i]  = wrap[i];
         end else begin
            acc_d[i] = sum[i][ACC_W-1:0];
            en_d[i]  = wrap[i];
            if (wrap[i] && (cnt_q[i] != LOCK_MAX))
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_comb begin
      pend_vld_d   = pend_vld_q;
      pend_ch_d    = pend_ch_q;
      pend_inc_d   = pend_inc_q;
      pend_phase_d = pend_phase_q;
      if (!sync && ((|apply) || pend_bad))
         pend_vld_d = 1'b0;
      if (accept) begin
         pend_vld_d   = 1'b1;
         pend_ch_d    = cfg.cfg_ch;
         pend_inc_d   = cfg.cfg_inc;
         pend_phase_d = cfg.cfg_phase;
      end
   end

   always_comb begin
      ch_locked = '0;
      for (int i = 0; i < CHANNELS; i++)
         ch_locked[i] = (cnt_q[i] == LOCK_MAX);
   end

   assign locked_d = &ch_locked;

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q        <= '0;
         inc_q        <= {CHANNELS{DEFAULT_INC}};
         phr_q        <= '0;
         cnt_q        <= '0;
         en_q         <= '0;
         locked_q     <= 1'b0;
         pend_vld_q   <= 1'b0;
         pend_ch_q    <= '0;
         pend_inc_q   <= '0;
         pend_phase_q <= '0;
      end else begin
         acc_q        <= acc_d;
         inc_q        <= inc_d;
         phr_q        <= phr_d;
         cnt_q        <= cnt_d;
         en_q         <= en_d;
         locked_q     <= locked_d;
         pend_vld_q   <= pend_vld_d;
         pend_ch_q    <= pend_ch_d;
         pend_inc_q   <= pend_inc_d;
         pend_phase_q <= pend_phase_d;
      end
   end

   assign en_out        = en_q;
   assign locked        = locked_q;
   assign cfg.cfg_ready = ~pend_vld_q;

endmodule

// File: tb/tb_clk_en_nco.sv
// Directed + randomized bench for clk_en_nco against an arithmetic channel model.
// Bench instance: ACC_W=8, CHANNELS=4, LOCK_CYCLES=4, DEFAULT_INC=8'h40, CH_W=3.
module tb_clk_en_nco;

   localparam int NCH  = 4;
   localparam int AW   = 8;
   localparam int LC   = 4;
   localparam int CW   = 3;
   localparam int MODV = 256;
   localparam int DINC = 64;

   logic           refclk;
   logic           rst_n;
   logic           sync_drv;
   logic [NCH-1:0] en_out;
   logic [NCH-1:0] ch_locked;
   logic           locked;

   clk_en_nco_if #(.CH_W(CW), .ACC_W(AW)) cfg ();

   clk_en_nco #(
      .CHANNELS(NCH), .ACC_W(AW), .DEFAULT_INC(8'h40),
      .LOCK_CYCLES(LC), .CH_W(CW)
   ) dut (
      .refclk(refclk),
      .rst_n(rst_n),
      .cfg(cfg.slave),
`ifdef CLK_EN_NCO_SYNC_EN
      .sync_req(sync_drv),
`endif
      .en_out(en_out),
      .ch_locked(ch_locked),
      .locked(locked)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   typedef struct {
      int ch;
      int inc;
      int ph;
   } req_t;

   int   m_acc [NCH];
   int   m_inc [NCH];
   int   m_ph  [NCH];
   int   m_cnt [NCH];
   bit   m_en  [NCH];
   bit   m_lock;
   req_t pq[$];

   int errs;
   int checks;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_acc[i] = 0;
         m_inc[i] = DINC;
         m_ph[i]  = 0;
         m_cnt[i] = 0;
         m_en[i]  = 1'b0;
      end
      m_lock = 1'b0;
      pq.delete();
   endtask

   // One refclk cycle of the channel rules, using the inputs as driven now.
   task automatic model_eval();
      bit sy, take, lk, used, w, ap;
      int s;
      sy   = sync_drv;
      take = cfg.cfg_valid && (pq.size() == 0);
      lk   = 1'b1;
      used = 1'b0;
      for (int i = 0; i < NCH; i++)
         lk &= (m_cnt[i] == LC);
      for (int i = 0; i < NCH; i++) begin
         s  = m_acc[i] + m_inc[i];
         w  = (s >= MODV);
         ap = (pq.size() > 0) && (pq[0].ch == i) && (w || m_inc[i] == 0) && !sy;
         if (sy) begin
            m_acc[i] = m_ph[i];
            m_cnt[i] = 0;
            m_en[i]  = 1'b0;
         end else if (ap) begin
            m_en[i]  = w;
            m_acc[i] = pq[0].ph;
            m_inc[i] = pq[0].inc;
            m_ph[i]  = pq[0].ph;
            m_cnt[i] = 0;
            used     = 1'b1;
         end else begin
            m_en[i]  = w;
            m_acc[i] = s % MODV;
            if (w && m_cnt[i] < LC) m_cnt[i]++;
         end
      end
      m_lock = lk;
      if (!sy && pq.size() > 0 && (used || pq[0].ch >= NCH))
         void'(pq.pop_front());
      if (take)
         pq.push_back('{int'(cfg.cfg_ch), int'(cfg.cfg_inc), int'(cfg.cfg_phase)});
   endtask

   function automatic logic [31:0] exp_en();
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < NCH; i++) v[i] = m_en[i];
      return v;
   endfunction

   function automatic logic [31:0] exp_lk();
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < NCH; i++) v[i] = (m_cnt[i] == LC);
      return v;
   endfunction

   task automatic step();
      model_eval();
      @(posedge refclk);
      #1;
      chk("en_out", 32'(en_out), exp_en());
      chk("ch_locked", 32'(ch_locked), exp_lk());
      chk("locked", 32'(locked), 32'(m_lock));
      chk("cfg_ready", 32'(cfg.cfg_ready), 32'(pq.size() == 0));
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic cfg_send(input int ch, input int inc, input int ph);
      bit done;
      done = 1'b0;
      cfg.cfg_valid = 1'b1;
      cfg.cfg_ch    = CW'(ch);
      cfg.cfg_inc   = AW'(inc);
      cfg.cfg_phase = AW'(ph);
      for (int k = 0; k < 600 && !done; k++) begin
         done = (pq.size() == 0);
         step();
      end
      chk("cfg_accept_timeout", 32'(done), 32'd1);
      cfg.cfg_valid = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_en"}, 32'(en_out), 32'd0);
      chk({tag, "_chl"}, 32'(ch_locked), 32'd0);
      chk({tag, "_lock"}, 32'(locked), 32'd0);
      chk({tag, "_rdy"}, 32'(cfg.cfg_ready), 32'd1);
   endtask

   initial begin
      errs          = 0;
      checks        = 0;
      rst_n         = 1'b0;
      sync_drv      = 1'b0;
      cfg.cfg_valid = 1'b0;
      cfg.cfg_ch    = '0;
      cfg.cfg_inc   = '0;
      cfg.cfg_phase = '0;
      model_reset();
      #22;
      chk_reset_vals("rst");
      @(negedge refclk);
      rst_n = 1'b1;

      // Default increment: all channels pulse together every 4 cycles.
      run(3);
      chk("pre_pulse", 32'(en_out), 32'h0);
      step();
      chk("first_pulse", 32'(en_out), 32'hF);
      run(12);
      chk("chl_set", 32'(ch_locked), 32'hF);
      chk("locked_lag", 32'(locked), 32'd0);
      step();
      chk("locked_set", 32'(locked), 32'd1);

      // Retune ch1 to half period.
      cfg_send(1, 8'h80, 0);
      chk("busy_after_accept", 32'(cfg.cfg_ready), 32'd0);
      run(24);

      // Back-to-back requests for ch2; second waits for the first apply.
      cfg_send(2, 8'h20, 8'h10);
      cfg_send(2, 8'h80, 8'h00);
      run(24);

      // Stop ch3, then restart it: second apply needs no wrap.
      cfg_send(3, 0, 0);
      run(6);
      chk("ch3_stopped", 32'(ch_locked[3]), 32'd0);
      cfg_send(3, 8'h20, 0);
      run(40);

      // Invalid channel is discarded.
      cfg_send(5, 8'h11, 8'h22);
      run(10);

      // Reset while a slow request is still pending.
      cfg_send(2, 1, 0);
      run(3);
      rst_n = 1'b0;
      #2;
      chk_reset_vals("midrst");
      model_reset();
      @(negedge refclk);
      rst_n = 1'b1;
      run(20);

`ifdef CLK_EN_NCO_SYNC_EN
      cfg_send(0, 8'h40, 8'h00);
      cfg_send(1, 8'h40, 8'h40);
      cfg_send(2, 8'h40, 8'h80);
      cfg_send(3, 8'h40, 8'hC0);
      run(20);
      sync_drv = 1'b1;
      step();
      sync_drv = 1'b0;
      run(20);
      cfg_send(0, 8'h10, 8'h00);
      sync_drv = 1'b1;
      run(3);
      sync_drv = 1'b0;
      run(40);
`endif

      for (int r = 0; r < 40; r++) begin
         int ch, inc, ph;
         ch  = $urandom_range(0, 5);
         inc = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 255);
         ph  = $urandom_range(0, 255);
         cfg_send(ch, inc, ph);
         run($urandom_range(0, 20));
      end
      run(30);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
